melody_sequencer: RTL and testbench

- Parametrised tone sequencer that plays a note list from an external synchronous note memory on a single square-wave output.
- Successor to the fixed free-running melody player, adding:
  - start/stop control
  - a selectable start address
  - an end-of-song marker
  - loop mode
  - a configurable note length and articulation gap
  - busy/done status
- Sits between a note ROM/BRAM and the buzzer pin.

---
 rtl/melody_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_melody_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Square-wave tone sequencer: walks a note list in a registered-read memory and
// drives one audio pin, with start/stop, loop, end marker and note/gap timing.
//
// state | meaning
// IDLE  | waiting for start, audio low
// FETCH | memory reading rom_addr
// LOAD  | note word captured, timers armed
// PLAY  | tone (or rest) for NOTE_TICKS-GAP_TICKS cycles
// GAP   | forced silence for GAP_TICKS cycles
// ADV   | step address or hit the last entry
// END   | wrap to start address (loop) or finish with done
module melody_sequencer #(
  parameter int          ADDR_W     = 8,
  parameter int          NOTE_W     = 8,
  parameter int          LAST_ADDR  = 255,
  parameter int unsigned NOTE_TICKS = 4194304,
  parameter int unsigned GAP_TICKS  = 262144
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic              audio_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_ADV, S_END
  } state_t;

  localparam logic [31:0]       PLAY_LAST = 32'(NOTE_TICKS - GAP_TICKS - 1);
  localparam logic [31:0]       GAP_LAST  = (GAP_TICKS == 0) ? 32'd0 : 32'(GAP_TICKS - 1);
  localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(LAST_ADDR);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [5:0]        pitch_q, pitch_d;
  logic [31:0]       tick_q, tick_d;
  logic [8:0]        dcnt_q, dcnt_d;
  logic [7:0]        ocnt_q, ocnt_d;
  logic              audio_q, audio_d;
  logic              done_q, done_d;

  logic [5:0] pitch_src;
  logic [5:0] oct_full;
  logic [5:0] semi_full;
  logic [8:0] d_base;
  logic [7:0] o_base;
  logic       unused_rom_bits;

  assign unused_rom_bits = ^rom_data[NOTE_W-2:6];

  // In LOAD the dividers are armed straight from the memory word.
  always_comb begin
    pitch_src = (state_q == S_LOAD) ? rom_data[5:0] : pitch_q;
    oct_full  = pitch_src / 6'd12;
    semi_full = pitch_src % 6'd12;
    o_base    = 8'hFF >> oct_full;
    case (semi_full)
      6'd0:    d_base = 9'd511;
      6'd1:    d_base = 9'd482;
      6'd2:    d_base = 9'd455;
      6'd3:    d_base = 9'd430;
      6'd4:    d_base = 9'd405;
      6'd5:    d_base = 9'd383;
      6'd6:    d_base = 9'd361;
      6'd7:    d_base = 9'd341;
      6'd8:    d_base = 9'd322;
      6'd9:    d_base = 9'd303;
      6'd10:   d_base = 9'd286;
      default: d_base = 9'd270;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      start_q <= '0;
      pitch_q <= '0;
      tick_q  <= '0;
      dcnt_q  <= '0;
      ocnt_q  <= '0;
      audio_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      pitch_q <= pitch_d;
      tick_q  <= tick_d;
      dcnt_q  <= dcnt_d;
      ocnt_q  <= ocnt_d;
      audio_q <= audio_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    start_d = start_q;
    pitch_d = pitch_q;
    tick_d  = tick_q;
    dcnt_d  = dcnt_q;
    ocnt_d  = ocnt_q;
    audio_d = audio_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        audio_d = 1'b0;
        if (start && !stop) begin
          addr_d  = start_addr;
          start_d = start_addr;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        pitch_d = rom_data[5:0];
        if (rom_data[NOTE_W-1]) begin
          state_d = S_END;
        end else begin
          tick_d  = PLAY_LAST;
          dcnt_d  = d_base;
          ocnt_d  = o_base;
          audio_d = 1'b0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick_q == 32'd0) begin
          audio_d = 1'b0;
          tick_d  = GAP_LAST;
          state_d = (GAP_TICKS == 0) ? S_ADV : S_GAP;
        end else begin
          tick_d = tick_q - 32'd1;
          // Cascade: O+1 passes of the D+1 divider per half-period.
          if (pitch_q != 6'd0) begin
            if (dcnt_q != 9'd0) begin
              dcnt_d = dcnt_q - 9'd1;
            end else begin
              dcnt_d = d_base;
              if (ocnt_q != 8'd0) begin
                ocnt_d = ocnt_q - 8'd1;
              end else begin
                ocnt_d  = o_base;
                audio_d = ~audio_q;
              end
            end
          end
        end
      end
      S_GAP: begin
        audio_d = 1'b0;
        if (tick_q == 32'd0) state_d = S_ADV;
        else                 tick_d  = tick_q - 32'd1;
      end
      S_ADV: begin
        audio_d = 1'b0;
        if (addr_q == LAST_A) begin
          state_d = S_END;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_END: begin
        audio_d = 1'b0;
        if (loop_en) begin
          addr_d  = start_q;
          state_d = S_FETCH;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      audio_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    rom_addr  = addr_q;
    audio_out = audio_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a short slot (7200 ticks, 200 gap)
// and a 4-entry song: [0]=63 (H=3448), [1]=rest, [2]=12 (H=65536), [3]=60 (H=4096).
module tb_melody_sequencer;

  localparam int S = 7203;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic [7:0] start_addr = '0;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic       busy, done, audio_out;

  logic [7:0] mem [0:255];

  int tests = 0;
  int failed = 0;
  int t;
  int done_cnt;
  int done_t;
  logic prev_audio;
  logic [7:0] prev_addr;
  int ch_q[$];
  int addr_q[$];
  int addr_t_q[$];

  melody_sequencer #(
    .ADDR_W(8), .NOTE_W(8), .LAST_ADDR(3), .NOTE_TICKS(7200), .GAP_TICKS(200)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop), .loop_en(loop_en),
    .start_addr(start_addr), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .done(done), .audio_out(audio_out)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) rom_data <= mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int ch_at(int i);
    if (i < ch_q.size()) return ch_q[i];
    return -1;
  endfunction

  function automatic int addr_at(int i);
    if (i < addr_q.size()) return addr_q[i];
    return -1;
  endfunction

  function automatic int addr_t_at(int i);
    if (i < addr_t_q.size()) return addr_t_q[i];
    return -1;
  endfunction

  task automatic run(input int ncyc, input bit til_idle);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK);
      t++;
      if (audio_out !== prev_audio) ch_q.push_back(t);
      prev_audio = audio_out;
      if (t == 1 || rom_addr !== prev_addr) begin
        addr_q.push_back(int'(rom_addr));
        addr_t_q.push_back(t);
      end
      prev_addr = rom_addr;
      if (done === 1'b1) begin
        done_cnt++;
        done_t = t;
      end
      if (til_idle && busy === 1'b0) break;
    end
  endtask

  task automatic start_play(input logic [7:0] sa, input logic lp);
    start_addr = sa;
    loop_en    = lp;
    start      = 1'b1;
    t          = 0;
    ch_q.delete();
    addr_q.delete();
    addr_t_q.delete();
    done_cnt   = 0;
    done_t     = -1;
    prev_audio = audio_out;
    prev_addr  = rom_addr;
    run(1, 1'b0);
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    run(1, 1'b0);
    stop = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'd63;
    mem[1] = 8'd0;
    mem[2] = 8'd12;
    mem[3] = 8'd60;

    repeat (2) @(negedge CLK);
    chk("rst_addr", rom_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_audio", audio_out, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Full song, no loop
    start_play(8'd0, 1'b0);
    chk("song_busy_rise", busy, 1);
    chk("song_first_addr", rom_addr, 0);
    run(30000, 1'b1);
    chk("song_done_cnt", done_cnt, 1);
    chk("song_done_time", done_t, 4 * S + 2);
    chk("song_busy_fall_time", t, 4 * S + 2);
    chk("song_busy_end", busy, 0);
    chk("song_toggle_cnt", ch_q.size(), 4);
    chk("e0_toggle1", ch_at(0), 3451);
    chk("e0_toggle2", ch_at(1), 3451 + 3448);
    chk("e3_toggle1", ch_at(2), 3 * S + 3 + 4096);
    chk("e3_gap_low", ch_at(3), 3 * S + 3 + 7000);
    chk("song_addr_cnt", addr_q.size(), 4);
    chk("song_addr3", addr_at(3), 3);
    chk("song_addr1_time", addr_t_at(1), S + 1);
    run(1, 1'b0);
    chk("done_one_cycle", done, 0);

    // start together with stop in IDLE is ignored
    start = 1'b1;
    stop  = 1'b1;
    run(1, 1'b0);
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_idle", busy, 0);

    // Loop from address 2; start while busy and start_addr changes are ignored
    start_play(8'd2, 1'b1);
    run(99, 1'b0);
    start_addr = 8'd0;
    start = 1'b1;
    run(1, 1'b0);
    start = 1'b0;
    run(14399, 1'b0);
    chk("loop_addr_cnt", addr_q.size(), 3);
    chk("loop_addr0", addr_at(0), 2);
    chk("loop_addr1", addr_at(1), 3);
    chk("loop_addr2", addr_at(2), 2);
    chk("loop_wrap_time", addr_t_at(2), 2 * S + 2);
    chk("loop_no_done", done_cnt, 0);
    chk("loop_busy", busy, 1);
    chk("loop_toggle_cnt", ch_q.size(), 2);
    chk("loop_e3_toggle", ch_at(0), S + 3 + 4096);
    chk("loop_e3_gap", ch_at(1), S + 3 + 7000);
    halt();
    chk("loop_stop_busy", busy, 0);
    chk("loop_stop_addr", rom_addr, 2);

    // END marker at entry 1
    mem[1] = 8'h80;
    start_play(8'd0, 1'b0);
    run(10000, 1'b1);
    chk("endm_done_cnt", done_cnt, 1);
    chk("endm_done_time", done_t, S + 4);
    chk("endm_addr_cnt", addr_q.size(), 2);
    chk("endm_toggle_cnt", ch_q.size(), 2);
    mem[1] = 8'd0;

    // stop mid-PLAY while audio is high
    start_play(8'd0, 1'b0);
    run(4999, 1'b0);
    chk("stop_pre_audio", audio_out, 1);
    halt();
    chk("stop_audio", audio_out, 0);
    chk("stop_busy", busy, 0);
    chk("stop_addr", rom_addr, 0);
    run(20, 1'b0);
    chk("stop_no_done", done_cnt, 0);
    start_play(8'd0, 1'b0);
    run(3500, 1'b0);
    chk("restart_toggle_cnt", ch_q.size(), 1);
    chk("restart_toggle", ch_at(0), 3451);
    halt();

    // RST mid-PLAY with start held
    start_play(8'd3, 1'b0);
    run(4999, 1'b0);
    chk("rstp_pre_audio", audio_out, 1);
    RST = 1'b1;
    start = 1'b1;
    run(1, 1'b0);
    chk("rstp_busy", busy, 0);
    chk("rstp_audio", audio_out, 0);
    chk("rstp_addr", rom_addr, 0);
    chk("rstp_done", done, 0);
    run(3, 1'b0);
    chk("rstp_held_busy", busy, 0);
    RST = 1'b0;
    start_play(8'd3, 1'b0);
    chk("rstp_accept_busy", busy, 1);
    chk("rstp_accept_addr", rom_addr, 3);
    run(4200, 1'b0);
    chk("rstp_toggle_cnt", ch_q.size(), 1);
    chk("rstp_toggle", ch_at(0), 4099);
    halt();
    chk("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
